// File: rtl/apb_spi_ctrl.sv
// apb_spi_ctrl -- APB3 register front-end for a 16-bit SPI shift engine.
//
// Queues transmit words in a TX FIFO and launches one engine transfer per
// word with a single-cycle start pulse. Each received word is captured into a
// one-entry RX holding register. Status and sticky error flags are visible to
// software.
//
// Optional feature: define APB_SPI_IRQ_EN to add the irq output and CTRL[2] IE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   psel/penable/pwrite/paddr/pwdata   APB3 request
//   prdata/pready/pslverr              APB3 response (pready tied 1)
//   spi_start    one-cycle launch pulse to the engine
//   spi_datain   word to the engine, held between transfers
//   spi_dataout  word received by the engine
//   spi_busy     engine busy flag
//   irq          (APB_SPI_IRQ_EN only) registered interrupt
//
// Register map (paddr[3:2]):
//   0x0 TXDATA  W    push pwdata[15:0]
//   0x4 RXDATA  R    {16'b0, rx_data}; the read clears RX_VALID
//   0x8 STATUS  R/W1C {RX_OVF, TX_OVF, TX_EMPTY, TX_FULL, RX_VALID, BUSY}
//   0xC CTRL    R/W  [0] ENABLE, [1] FLUSH (write-only), [2] IE (optional)
module apb_spi_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              spi_start,
  output logic [15:0]       spi_datain,
  input  logic [15:0]       spi_dataout,
  input  logic              spi_busy
`ifdef APB_SPI_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_XFER} state_t;

  state_t      r_state;
  logic [15:0] r_fifo_mem [TX_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [15:0] r_rx_data;
  logic        r_rx_valid;
  logic        r_tx_ovf;
  logic        r_rx_ovf;
  logic        r_enable;
  logic        r_spi_start;
  logic [15:0] r_spi_datain;

  logic        w_access, w_wr, w_rd;
  logic [1:0]  w_sel;
  logic        w_empty, w_full, w_busy;
  logic        w_push, w_tx_ovf_evt, w_flush, w_rx_read, w_stat_wr, w_ctrl_wr;
  logic        w_launch, w_capture;
  logic        w_ie;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_access = psel & penable;
  assign w_wr     = w_access & pwrite;
  assign w_rd     = w_access & ~pwrite;
  assign w_sel    = paddr[3:2];

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_busy  = (r_state != S_IDLE) || !w_empty;

  assign w_push       = w_wr && (w_sel == 2'd0) && !w_full;
  assign w_tx_ovf_evt = w_wr && (w_sel == 2'd0) && w_full;
  assign w_rx_read    = w_rd && (w_sel == 2'd1);
  assign w_stat_wr    = w_wr && (w_sel == 2'd2);
  assign w_ctrl_wr    = w_wr && (w_sel == 2'd3);
  assign w_flush      = w_ctrl_wr && pwdata[1];

  assign w_launch  = (r_state == S_IDLE) && r_enable && !w_empty && !spi_busy;
  assign w_capture = (r_state == S_XFER) && !spi_busy;

  assign w_status = {26'b0, r_rx_ovf, r_tx_ovf, w_empty, w_full, r_rx_valid, w_busy};

  assign pready     = 1'b1;
  assign spi_start  = r_spi_start;
  assign spi_datain = r_spi_datain;

  assign w_unused = ^{pwdata[31:16], paddr};

`ifdef APB_SPI_IRQ_EN
  logic r_ie;
  logic r_irq;
  assign w_ie = r_ie;
  assign irq  = r_irq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= pwdata[2];
      r_irq <= r_ie & (r_rx_valid | r_tx_ovf | r_rx_ovf);
    end
  end
`else
  assign w_ie = 1'b0;
`endif

  // Response is combinational and only non-zero during the access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (w_access) begin
      case (w_sel)
        2'd0: if (pwrite) pslverr = w_full;
        2'd1: if (pwrite) pslverr = 1'b1;
              else        prdata  = {16'b0, r_rx_data};
        2'd2: if (!pwrite) prdata = w_status;
        default: if (!pwrite) prdata = {29'b0, w_ie, 1'b0, r_enable};
      endcase
    end
  end

  // FIFO storage: no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[AW-1:0]] <= pwdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      // A launch in this cycle has already latched its head word.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_launch) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_spi_start  <= 1'b0;
      r_spi_datain <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_ovf     <= 1'b0;
      r_rx_ovf     <= 1'b0;
      r_enable     <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      case (r_state)
        S_IDLE: if (w_launch) begin
          r_spi_datain <= r_fifo_mem[r_rd_ptr[AW-1:0]];
          r_spi_start  <= 1'b1;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: if (spi_busy) r_state <= S_XFER;
        S_XFER:      if (!spi_busy) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase

      // Capture beats a same-cycle RXDATA read (the read sees the old word).
      if (w_capture) begin
        r_rx_data  <= spi_dataout;
        r_rx_valid <= 1'b1;
      end else if (w_rx_read) begin
        r_rx_valid <= 1'b0;
      end

      if (w_capture && r_rx_valid && !w_rx_read) r_rx_ovf <= 1'b1;
      else if (w_stat_wr && pwdata[5])           r_rx_ovf <= 1'b0;

      if (w_tx_ovf_evt)                  r_tx_ovf <= 1'b1;
      else if (w_stat_wr && pwdata[4])   r_tx_ovf <= 1'b0;

      if (w_ctrl_wr) r_enable <= pwdata[0];
    end
  end

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Directed testbench for apb_spi_ctrl with a behavioural SPI engine that
// returns the nibble-reversed transmit word three busy cycles after start.
module tb_apb_spi_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, spi_start;
  logic [15:0] spi_datain;
  logic [15:0] spi_dataout = '0;
  logic        spi_busy = 1'b0;
`ifdef APB_SPI_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  int start_cycles = 0;
  int n_launch = 0;
  logic [15:0] launched [16];

  apb_spi_ctrl #(.TX_DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .spi_start(spi_start), .spi_datain(spi_datain),
    .spi_dataout(spi_dataout), .spi_busy(spi_busy)
`ifdef APB_SPI_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nib_rev(input logic [15:0] d);
    return {d[3:0], d[7:4], d[11:8], d[15:12]};
  endfunction

  // Count every cycle spi_start is high.
  initial forever begin
    @(negedge clk);
    if (spi_start) start_cycles++;
  end

  // Engine model: busy rises one cycle after start, lasts three cycles.
  initial forever begin
    @(negedge clk);
    if (spi_start) begin
      logic [15:0] d;
      d = spi_datain;
      if (n_launch < 16) launched[n_launch] = d;
      n_launch++;
      @(posedge clk); #1 spi_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 spi_busy = 1'b0;
      spi_dataout = nib_rev(d);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tasks start and end at posedge+1.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("APB WR addr=%h data=%h pslverr=%0b", a, d, err);
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1 penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    $display("APB RD addr=%h data=%h pslverr=%0b", a, d, err);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        ok;
    logic [15:0] words [5];
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    words[3] = 16'hDEF0; words[4] = 16'h0F0F;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_start", {31'b0, spi_start}, 32'd0);
    chk("rst_spi_datain", {16'b0, spi_datain}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("pready", {31'b0, pready}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    apb_read(8'h08, rd, err); chk("rst_status", rd, 32'h08);
    apb_read(8'h0C, rd, err); chk("rst_ctrl", rd, 32'h00);

    // Single transfer
    apb_write(8'h0C, 32'h1, err);
    apb_write(8'h00, 32'hA5C3, err); chk("tx1_err", {31'b0, err}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      apb_read(8'h08, rd, err);
      ok = rd[1];
    end
    chk("tx1_rx_valid", {31'b0, ok}, 32'd1);
    chk("tx1_pulses", start_cycles, 32'd1);
    chk("tx1_datain", {16'b0, launched[0]}, 32'hA5C3);
    apb_read(8'h04, rd, err); chk("tx1_rxdata", rd, 32'h3C5A);
    apb_read(8'h08, rd, err); chk("tx1_status_after", rd, 32'h08);

    // Overflow with ENABLE=0
    apb_write(8'h0C, 32'h0, err);
    for (int i = 0; i < 5; i++) begin
      apb_write(8'h00, {16'b0, words[i]}, err);
      chk($sformatf("ovf_err%0d", i), {31'b0, err}, (i == 4) ? 32'd1 : 32'd0);
    end
    apb_read(8'h08, rd, err); chk("ovf_status", rd, 32'h15);
    apb_write(8'h08, 32'h10, err);
    apb_read(8'h08, rd, err); chk("ovf_w1c", rd, 32'h05);
    apb_write(8'h04, 32'h0, err); chk("rxdata_wr_err", {31'b0, err}, 32'd1);

    // Drain four words without reading RXDATA
    apb_write(8'h0C, 32'h1, err);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      apb_read(8'h08, rd, err);
      ok = !rd[0];
    end
    chk("drain_idle", {31'b0, ok}, 32'd1);
    chk("drain_pulses", start_cycles, 32'd5);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_order%0d", i), {16'b0, launched[i+1]}, {16'b0, words[i]});
    chk("drain_status", rd, 32'h2A);
    apb_read(8'h04, rd, err); chk("drain_rxdata", rd, 32'h0FED);
    apb_write(8'h08, 32'h20, err);
    apb_read(8'h08, rd, err); chk("drain_clear", rd, 32'h08);

    // Flush
    apb_write(8'h0C, 32'h0, err);
    apb_write(8'h00, 32'h1111, err);
    apb_write(8'h00, 32'h2222, err);
    apb_write(8'h0C, 32'h2, err);
    apb_read(8'h0C, rd, err); chk("flush_ctrl", rd, 32'h0);
    apb_read(8'h08, rd, err); chk("flush_status", rd, 32'h08);
    apb_write(8'h0C, 32'h3, err);
    apb_read(8'h0C, rd, err); chk("ctrl_rb", rd, 32'h1);
    chk("flush_pulses", start_cycles, 32'd5);

    // Reset during XFER
    apb_write(8'h00, 32'hBEEF, err);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1 ok = spi_busy;
    end
    chk("xfer_busy_seen", {31'b0, ok}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("xrst_spi_start", {31'b0, spi_start}, 32'd0);
    chk("xrst_datain", {16'b0, spi_datain}, 32'd0);
    reset = 1'b1;
    apb_read(8'h08, rd, err); chk("xrst_status", rd, 32'h08);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1 ok = !spi_busy;
    end
    chk("xrst_busy_fall", {31'b0, ok}, 32'd1);
    repeat (3) @(posedge clk); #1;
    apb_read(8'h08, rd, err); chk("xrst_no_capture", rd, 32'h08);
    apb_read(8'h04, rd, err); chk("xrst_rxdata", rd, 32'h0);
    chk("xrst_pulses", start_cycles, 32'd6);

`ifdef APB_SPI_IRQ_EN
    apb_write(8'h0C, 32'h5, err);
    apb_read(8'h0C, rd, err); chk("irq_ctrl", rd, 32'h5);
    chk("irq_low", {31'b0, irq}, 32'd0);
    apb_write(8'h00, 32'h0123, err);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      apb_read(8'h08, rd, err);
      ok = rd[1];
    end
    chk("irq_rx_valid", {31'b0, ok}, 32'd1);
    chk("irq_high", {31'b0, irq}, 32'd1);
    apb_read(8'h04, rd, err); chk("irq_rxdata", rd, 32'h3210);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    chk("irq_drop", {31'b0, irq}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_spi_ctrl.md
Name: apb_spi_ctrl

Overview:
APB3 slave register front-end that sits directly upstream of the 16-bit SPI shift engine in the APB-to-SPI bridge. It buffers transmit words in a small TX FIFO, launches one engine transfer per word with a single-cycle start pulse, and tracks the engine busy flag. On each completion it captures the received word into a one-entry RX holding register and exposes status and sticky error flags to software.

Parameters:
TX_DEPTH, 4, TX FIFO depth in 16-bit words; must be a power of 2, minimum 2
ADDR_W, 8, APB address width (byte address; only paddr[3:2] decoded)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  always 1 (zero wait states)
pslverr  out  1  access-phase error
spi_start  out  1  one-cycle launch pulse to engine
spi_datain  out  16  word to engine; valid while spi_start=1
spi_dataout  in  16  engine received word; valid once busy falls
spi_busy  in  1  engine busy flag

Behaviour:
- Reset (reset=0 at clk edge): prdata=0, pslverr=0, spi_start=0, spi_datain=0. FIFO empty, rx_data=0, all status bits 0, FSM=IDLE. A reset taken mid-transfer drops the FIFO contents and the in-flight result.
- APB access completes when psel&penable are both 1. Registers:
  - 0x0 TXDATA (W): pushes pwdata[15:0]. If the FIFO is full: word dropped, pslverr=1 in that access phase, TX_OVF set.
  - 0x4 RXDATA (R): prdata={16'b0,rx_data}. The read clears RX_VALID.
  - 0x8 STATUS (R, W1C): [0] BUSY (FSM!=IDLE or FIFO non-empty; read-only), [1] RX_VALID (read-only), [2] TX_FULL (read-only), [3] TX_EMPTY (read-only), [4] TX_OVF (sticky, W1C), [5] RX_OVF (sticky, W1C).
  - 0xC CTRL (R/W): [0] ENABLE (reset 0). Bit [1] is write-only FLUSH: a write with bit [1]=1 empties the FIFO and reads back 0. FLUSH never aborts an in-flight transfer.
- Reads and writes to unmapped offsets, and writes to RXDATA: pslverr=1, no side effects. Unmapped reads return prdata=0.
- prdata and pslverr are driven combinationally during the access phase. Outside the access phase they are 0.
- FIFO: circular, with log2(TX_DEPTH)+1-bit pointers so full and empty are distinguishable; pointers wrap at TX_DEPTH. A push and a pop in the same cycle are both honoured, so the count is unchanged. A push into a full FIFO is rejected even if a pop occurs in that cycle.
- FSM:
  - IDLE: if ENABLE=1, FIFO not empty and spi_busy=0, pop the head word, drive spi_datain=head, assert spi_start for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for spi_busy=1 (the engine raises it one cycle after start), then go to XFER.
  - XFER: wait for spi_busy=0. In that cycle, rx_data<=spi_dataout and RX_VALID<=1; if RX_VALID was already 1 and is not being cleared in that same cycle, set RX_OVF. Then go to IDLE.
- Simultaneous RXDATA read and capture: the read returns the old rx_data, and the capture wins (RX_VALID stays 1, no RX_OVF).
- Clearing ENABLE while in WAIT_BUSY or XFER lets the current transfer finish. No new launches occur while ENABLE=0.
- Back-to-back throughput: minimum 1 idle cycle between a completion and the next spi_start.
- spi_datain holds its last launched value between transfers.

Optional Feature:
- Macro APB_SPI_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and CTRL[2] IE (reset 0).
  - irq is registered: irq <= IE & (RX_VALID | TX_OVF | RX_OVF).
  - irq reset value is 0.
- Undefined:
  - No irq port exists.
  - CTRL[2] reads 0 and ignores writes.

Test Plan:
- Reset, then read STATUS -> 0x08 (TX_EMPTY only). Read CTRL -> 0.
- Write CTRL=1, write TXDATA=0xA5C3, engine model echoes 0x3C5A -> exactly one spi_start pulse with spi_datain=0xA5C3. After busy falls, STATUS[1]=1 and RXDATA reads 0x00003C5A. The next STATUS read shows RX_VALID=0.
- With ENABLE=0, write 5 words (TX_DEPTH=4) -> 5th access pslverr=1, STATUS=0x15 (BUSY, TX_FULL, TX_OVF). Write STATUS=0x10 -> TX_OVF clears.
- Enable with 4 queued words and never read RXDATA -> 4 spi_start pulses in FIFO order. RX_OVF=1 and RXDATA holds the 4th received word.
- Reset asserted while in XFER -> next cycle spi_start=0, FIFO empty, STATUS=0x08, no capture on the later busy fall.
- APB_SPI_IRQ_EN defined: CTRL=0x5, one transfer -> irq rises one cycle after RX_VALID sets. Reading RXDATA drops irq one cycle later.
